// File: rtl/regfile_seq_if.sv
// regfile_seq_if: register file bus (two read ports, one write port, clear request, ready/wr_drop status)
interface regfile_seq_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic [AW-1:0]    raddr1;
  logic [AW-1:0]    raddr2;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata2;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             clr;
  logic             ready;
  logic             wr_drop;
  modport master (
    output raddr1, raddr2, we, waddr, wdata, clr,
    input  rdata1, rdata2, ready, wr_drop
  );
  modport slave (
    input  raddr1, raddr2, we, waddr, wdata, clr,
    output rdata1, rdata2, ready, wr_drop
  );
endinterface

// File: rtl/regfile_seq.sv
// regfile_seq: clocked 2R/1W register file with bypass, optional zero register and a clear sequencer (ports: clk, rst, bus slave)
module regfile_seq #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_seq_if.slave bus
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [AW:0]   DEP  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t           state;
  logic [AW-1:0]    cnt;
  logic             ready;
  logic             wr_drop;
  logic             wlegal;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ra [2];
  logic [WIDTH-1:0] rd [2];
  assign wlegal = bus.we && ({1'b0, bus.waddr} < DEP) && !(ZERO_REG != 0 && bus.waddr == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      cnt     <= '0;
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= bus.we && state == INIT;
      if (state == INIT) begin
        cnt <= (bus.clr || cnt == LAST) ? '0 : cnt + 1'b1;
        if (!bus.clr && cnt == LAST) begin
          state <= RUN;
          ready <= 1'b1;
        end
      end else if (bus.clr) begin
        state <= INIT;
        cnt   <= '0;
        ready <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) mem[cnt] <= '0;
      else if (wlegal) mem[bus.waddr] <= bus.wdata;
    end
  end
  assign ra[0] = bus.raddr1;
  assign ra[1] = bus.raddr2;
  for (genvar i = 0; i < 2; i++) begin : g_rd
    assign rd[i] = (!ready || {1'b0, ra[i]} >= DEP || (ZERO_REG != 0 && ra[i] == '0)) ? '0 :
                   (BYPASS != 0 && wlegal && bus.waddr == ra[i]) ? bus.wdata : mem[ra[i]];
  end
  assign bus.rdata1  = rd[0];
  assign bus.rdata2  = rd[1];
  assign bus.ready   = ready;
  assign bus.wr_drop = wr_drop;
endmodule

// File: doc/regfile_seq.md
# regfile_seq

Parametrised, clocked general-purpose register file for the single-cycle processor datapath. It supersedes the unclocked two-read/one-write array. The block adds:
- a synchronous write port and two combinational read ports with optional write-to-read bypass;
- an optional hardwired zero register;
- a clear sequencer that zeroes every entry after reset or on request, with a `ready` handshake gating writes.

## Interface

Parameters:
- `WIDTH`, 32: data width in bits.
- `DEPTH`, 32: number of entries, 2..256. Need not be a power of two.
- `AW`, 5: address width. Must satisfy 2^AW >= DEPTH.
- `ZERO_REG`, 1: when 1, entry 0 always reads 0 and ignores writes.
- `BYPASS`, 1: when 1, a same-cycle write is forwarded to matching read ports.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous active-high reset.
- `raddr1` input AW: read port 1 address.
- `raddr2` input AW: read port 2 address.
- `rdata1` output WIDTH: read port 1 data, combinational.
- `rdata2` output WIDTH: read port 2 data, combinational.
- `we` input 1: write enable.
- `waddr` input AW: write address.
- `wdata` input WIDTH: write data.
- `clr` input 1: request a full clear, single-cycle pulse.
- `ready` output 1: registered. 1 means the array is initialised and accepting writes.
- `wr_drop` output 1: registered one-cycle pulse. Flags that a write was refused.

## Operation

The state machine has two states, INIT and RUN.

- **Reset.** An edge with `rst`=1 forces: state INIT, clear counter 0, `ready`=0, `wr_drop`=0. Array contents are not touched by `rst` itself.
- **INIT.**
  - Each edge with `rst`=0 writes 0 to entry[counter] and then increments the counter.
  - The edge that clears entry DEPTH-1 moves the state to RUN and sets `ready`=1.
- **RUN.** `ready`=1. An edge with `we`=1 writes `wdata` to entry[`waddr`], with these exceptions:
  - If `waddr` >= DEPTH, the write is ignored.
  - If `ZERO_REG`=1 and `waddr`=0, the write is ignored.
  - Neither ignored case raises `wr_drop`.
- **Clear request.**
  - `clr`=1 in RUN: the next edge enters INIT with counter 0 and `ready`=0.
  - `clr`=1 in INIT: the counter restarts at 0.
  - `rst` has priority over `clr`.
  - A write presented in the same cycle as `clr` in RUN is performed at that edge. The entry is zeroed again by the sequence.
- **Dropped writes.** An edge with `we`=1 and `ready`=0 (INIT or `rst`) does not modify the array. If `rst`=0 at that edge, `wr_drop` is 1 for the following cycle; otherwise `wr_drop` is 0.
- **Reads** are combinational, evaluated in priority order:
  1. If `ready`=0, the read returns 0.
  2. Otherwise, if the address >= DEPTH, the read returns 0.
  3. Otherwise, if `ZERO_REG`=1 and the address is 0, the read returns 0.
  4. Otherwise, if `BYPASS`=1, `we`=1, `waddr` equals the read address, and the write is legal, the read returns `wdata`.
  5. Otherwise, the read returns entry[address].
- Both read ports are independent. They may share an address with each other and with the write port.

## Timing

- Write latency: 1 edge. With `BYPASS`=0, the written value is visible on reads in the cycle after the write edge. With `BYPASS`=1, it is visible in the same cycle.
- Clear latency:
  - After the last `rst`=1 edge, `ready` rises after exactly DEPTH further edges with `rst`=0 and `clr`=0.
  - After a `clr` edge in RUN, `ready` falls at that edge and rises DEPTH edges later.
- `ready` and `wr_drop` are driven only from flops. No combinational path exists from `we` or `clr` to either output.
- Mid-sequence `rst` or `clr` restarts the count from entry 0. Partially cleared entries stay cleared.
- No read-during-write hazard exists beyond the bypass rule. The array has a single write port, so write/write collisions cannot occur.

## Test plan

1. **Reset and init.** Assert `rst` for 2 cycles, then release with DEPTH=32. Required: `ready`=0 for 32 edges and 1 after the 32nd. All reads return 0 throughout.
2. **Write/read and bypass.** In RUN, write 0xDEADBEEF to addr 5.
   - `BYPASS`=1: `rdata1` (raddr1=5) shows 0xDEADBEEF in the same cycle.
   - `BYPASS`=0: it shows the old value in that cycle and 0xDEADBEEF the next cycle.
   - `rdata2` (raddr2=5) matches `rdata1` in both configurations.
3. **Zero register.** With `ZERO_REG`=1, write 0x1234 to addr 0. Required: reads of addr 0 return 0 and `wr_drop` stays 0. With `ZERO_REG`=0, reads of addr 0 return 0x1234.
4. **Dropped write.** During INIT, assert `we` with `waddr`=3 and `wdata`=0xFF. Required: `wr_drop`=1 for exactly one cycle, and entry 3 reads 0 after `ready` rises.
5. **Clear request.** Fill entries 1..31 with nonzero values, then pulse `clr`. Required:
   - `ready` falls at the next edge.
   - Re-pulsing `clr` at count 10 restarts the sequence, so `ready` returns 32 edges after the second pulse.
   - All entries read 0 once `ready` returns.
6. **Out-of-range and odd depth.** With DEPTH=20 and AW=5, write to addr 25 and read addr 25. Required: the read returns 0, no entry changes, `wr_drop`=0, and init takes 20 edges.
